// File: rtl/mvu_data_loader.sv
// Bulk loader feeding the MVU data-bank write port from a fill word or a buffered word stream.
// Latency: command accepted at edge T -> first wrc_en at T+1; one word per cycle at full grant.
// Backpressure: writes held stable until every masked MVU grants; s_ready drops when FIFO full or burst satisfied.
module mvu_data_loader #(
   parameter int NMVU       = 1,
   parameter int BDBANKA    = 15,
   parameter int BDBANKW    = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [BDBANKA-1:0] cmd_addr,
   input  logic [BDBANKA-1:0] cmd_len,
   input  logic [NMVU-1:0]    cmd_mask,
   input  logic               cmd_fill,
   input  logic [BDBANKW-1:0] cmd_word,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [BDBANKW-1:0] s_word,
   output logic [NMVU-1:0]    wrc_en,
   input  logic [NMVU-1:0]    wrc_grnt,
   output logic [BDBANKA-1:0] wrc_addr,
   output logic [BDBANKW-1:0] wrc_word,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PW + 1;
   localparam int LEN_W = BDBANKA + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state;
   logic [BDBANKA-1:0] addr;
   logic [LEN_W-1:0]   len_p1;     // burst word count (len+1), wide enough for a full bank
   logic [LEN_W-1:0]   words_in;   // stream words accepted this burst
   logic [LEN_W-1:0]   words_out;  // words written this burst
   logic [NMVU-1:0]    mask;
   logic               fill;
   logic [BDBANKW-1:0] fill_word;

   logic [BDBANKW-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]      rd_ptr;
   logic [PW-1:0]      wr_ptr;
   logic [CNT_W-1:0]   count;

   logic fifo_full;
   logic issue;
   logic accept;
   logic push;
   logic pop;
   logic last;

   // Everything below is decoded from registers only, so grant never reaches the write outputs.
   assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
   assign issue     = (state == RUN) && (fill || (count != '0));
   assign accept    = issue && ((wrc_grnt & mask) == mask);
   assign last      = accept && ((words_out + LEN_W'(1)) == len_p1);
   assign s_ready   = (state == RUN) && !fill && !fifo_full && (words_in < len_p1);
   assign push      = s_valid && s_ready;
   assign pop       = accept && !fill;

   assign wrc_en   = issue ? mask : '0;
   assign wrc_addr = issue ? addr : '0;
   assign wrc_word = issue ? (fill ? fill_word : mem[rd_ptr]) : '0;

   // Control FSM: latch command, count words in/out, flag zero mask and address wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         addr      <= '0;
         len_p1    <= '0;
         words_in  <= '0;
         words_out <= '0;
         mask      <= '0;
         fill      <= 1'b0;
         fill_word <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (cmd_valid) begin
                  addr      <= cmd_addr;
                  len_p1    <= LEN_W'(cmd_len) + LEN_W'(1);
                  mask      <= cmd_mask;
                  fill      <= cmd_fill;
                  fill_word <= cmd_word;
                  words_in  <= '0;
                  words_out <= '0;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (cmd_mask == '0) begin
                     err   <= 1'b1;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     err   <= 1'b0;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (push) words_in <= words_in + LEN_W'(1);
               if (accept) begin
                  addr      <= addr + BDBANKA'(1);
                  words_out <= words_out + LEN_W'(1);
                  // Only a wrap that is followed by another write lands in the wrong place.
                  if ((&addr) && !last) err <= 1'b1;
                  if (last) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               done      <= 1'b0;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Stream FIFO pointers and occupancy; reset empties it even mid-burst.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage, contents only meaningful below the occupancy count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= s_word;
   end

endmodule

// File: tb/tb_mvu_data_loader.sv
// Self-checking bench for mvu_data_loader: directed table, hand-written corner sequences, random commands.
// Expected writes come from an address/word list model built per command.
// Grant and stream-valid are randomized per cycle to exercise stalls and back-pressure.
module tb_mvu_data_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [14:0] cmd_addr;
   logic [14:0] cmd_len;
   logic [1:0]  cmd_mask;
   logic        cmd_fill;
   logic [63:0] cmd_word;
   logic        s_valid;
   logic        s_ready;
   logic [63:0] s_word;
   logic [1:0]  wrc_en;
   logic [1:0]  wrc_grnt;
   logic [14:0] wrc_addr;
   logic [63:0] wrc_word;
   logic        busy;
   logic        done;
   logic        err;

   mvu_data_loader #(.NMVU(2), .BDBANKA(15), .BDBANKW(64), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .cmd_mask(cmd_mask), .cmd_fill(cmd_fill), .cmd_word(cmd_word),
      .s_valid(s_valid), .s_ready(s_ready), .s_word(s_word),
      .wrc_en(wrc_en), .wrc_grnt(wrc_grnt), .wrc_addr(wrc_addr), .wrc_word(wrc_word),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [14:0] addr;
      logic [14:0] len;
      logic [1:0]  mask;
      logic        fill;
      logic [63:0] word;
      int          gnt_pct;
      int          prod_pct;
      logic        rnd;       // stream words random, else alternating word / ~word
      logic        exp_err;
      int          exp_nwr;
   } cmd_t;

   typedef struct {
      logic [14:0] addr;
      logic [63:0] word;
      logic [1:0]  en;
      int          cyc;
   } wr_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          gnt_pct = 100;
   int          prod_pct = 100;
   int          done_cnt = 0;
   int          push_cnt = 0;
   logic [63:0] src_q[$];
   wr_t         got_q[$];
   wr_t         exp_q[$];
   logic        exp_err_m;
   logic        pend = 1'b0;
   logic [1:0]  p_en;
   logic [14:0] p_addr;
   logic [63:0] p_word;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Grant generator: each MVU grants independently with probability gnt_pct.
   initial begin
      wrc_grnt = '0;
      forever begin
         @(posedge clk); #1;
         for (int b = 0; b < 2; b++) wrc_grnt[b] = (int'($urandom_range(99)) < gnt_pct);
      end
   end

   // Stream source: presents the head of src_q with probability prod_pct.
   initial begin
      s_valid = 1'b0;
      s_word  = '0;
      forever begin
         @(posedge clk); #1;
         if (src_q.size() > 0 && int'($urandom_range(99)) < prod_pct) begin
            s_valid = 1'b1;
            s_word  = src_q[0];
         end else begin
            s_valid = 1'b0;
         end
      end
   end

   // Monitor: records accepted writes, stream handshakes, done pulses; checks stall stability.
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (pend) begin
            chk("hold_en", wrc_en, p_en);
            chk("hold_addr", wrc_addr, p_addr);
            chk("hold_word", wrc_word, p_word);
         end
         if (wrc_en != 2'b00 && (wrc_grnt & wrc_en) == wrc_en)
            got_q.push_back('{addr: wrc_addr, word: wrc_word, en: wrc_en, cyc: cyc});
         pend   = (wrc_en != 2'b00) && ((wrc_grnt & wrc_en) != wrc_en);
         p_en   = wrc_en;
         p_addr = wrc_addr;
         p_word = wrc_word;
         if (s_valid && s_ready) begin
            push_cnt++;
            if (src_q.size() > 0) void'(src_q.pop_front());
         end
         if (done) done_cnt++;
      end else begin
         pend = 1'b0;
      end
   end

   // Builds the expected write list and stream, then hands the command to the DUT.
   task automatic start_cmd(input cmd_t c);
      wr_t w;
      int  n;
      @(negedge clk);
      got_q.delete(); exp_q.delete(); src_q.delete();
      done_cnt = 0;
      push_cnt = 0;
      gnt_pct  = c.gnt_pct;
      prod_pct = c.prod_pct;
      for (int i = 0; i <= int'(c.len); i++) begin
         w.addr = 15'((int'(c.addr) + i) % 32768);
         if (c.fill)      w.word = c.word;
         else if (c.rnd)  w.word = {$urandom, $urandom};
         else             w.word = (i % 2 == 0) ? c.word : ~c.word;
         w.en  = c.mask;
         w.cyc = 0;
         if (!c.fill) src_q.push_back(w.word);
         if (c.mask != 2'b00) exp_q.push_back(w);
      end
      exp_err_m = (c.mask == 2'b00) || (int'(c.addr) + int'(c.len) > 32767);
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_addr  = c.addr;
      cmd_len   = c.len;
      cmd_mask  = c.mask;
      cmd_fill  = c.fill;
      cmd_word  = c.word;
      n = 0;
      while (n < 50) begin
         @(negedge clk);
         if (cmd_ready) break;
         n++;
      end
      chk("cmd_accept_seen", (n < 50), 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   // Waits for done (bounded) and compares writes, err and stream consumption.
   task automatic finish_cmd(input string name, input logic e_err, input int e_nwr,
                             input int e_push, input int budget);
      int n;
      n = 0;
      while (n < budget) begin
         @(negedge clk); #1;
         if (done_cnt > 0) break;
         n++;
      end
      chk({name, "_done_seen"}, (done_cnt > 0), 1);
      @(negedge clk); #1;
      chk({name, "_done_once"}, done_cnt, 1);
      chk({name, "_nwr"}, got_q.size(), e_nwr);
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         chk({name, "_addr"}, got_q[i].addr, exp_q[i].addr);
         chk({name, "_word"}, got_q[i].word, exp_q[i].word);
         chk({name, "_en"}, got_q[i].en, exp_q[i].en);
      end
      chk({name, "_err"}, err, e_err);
      chk({name, "_push"}, push_cnt, e_push);
      chk({name, "_idle_ready"}, cmd_ready, 1);
      chk({name, "_idle_busy"}, busy, 0);
   endtask

   cmd_t vec[7];
   cmd_t c;
   int   pct_tab[3] = '{100, 70, 50};

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
      cmd_mask = '0; cmd_fill = 1'b0; cmd_word = '0;

      //             addr      len    mask   fill  word                    gnt  prod rnd err nwr
      vec[0] = '{15'h0000, 15'd3, 2'b01, 1'b1, 64'hffff_ffff_ffff_ffff, 100, 100, 1, 0, 4};
      vec[1] = '{15'h7FFE, 15'd3, 2'b11, 1'b1, 64'h0123_4567_89ab_cdef, 100, 100, 1, 1, 4};
      vec[2] = '{15'h1234, 15'd5, 2'b10, 1'b0, 64'h0,                    60,  50, 1, 0, 6};
      vec[3] = '{15'h0005, 15'd2, 2'b00, 1'b1, 64'hdead_beef_0000_0001, 100, 100, 1, 1, 0};
      vec[4] = '{15'h0010, 15'd2, 2'b00, 1'b0, 64'h0,                   100, 100, 1, 1, 0};
      vec[5] = '{15'h0777, 15'd0, 2'b11, 1'b1, 64'hcafe_f00d_1234_5678, 100, 100, 1, 0, 1};
      vec[6] = '{15'h0100, 15'd0, 2'b01, 1'b0, 64'h0,                    50, 100, 1, 0, 1};

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_wrc_en", wrc_en, 0);
      chk("rst_wrc_addr", wrc_addr, 0);
      chk("rst_wrc_word", wrc_word, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed table.
      for (int v = 0; v < 7; v++) begin
         start_cmd(vec[v]);
         finish_cmd($sformatf("vec%0d", v), vec[v].exp_err, vec[v].exp_nwr,
                    (!vec[v].fill && vec[v].mask != 2'b00) ? int'(vec[v].len) + 1 : 0,
                    40 * (int'(vec[v].len) + 1) + 100);
         if (vec[v].fill && vec[v].gnt_pct == 100)
            for (int i = 1; i < got_q.size(); i++)
               chk($sformatf("vec%0d_b2b", v), got_q[i].cyc, got_q[0].cyc + i);
      end

      // Single-word fill latency: wrc_en at T+1, done at T+2.
      @(negedge clk);
      gnt_pct = 100;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_addr = 15'h0042; cmd_len = 15'd0; cmd_mask = 2'b01;
      cmd_fill = 1'b1; cmd_word = 64'h1111_2222_3333_4444;
      @(negedge clk);
      chk("lat_T_ready", cmd_ready, 1);
      chk("lat_T_en", wrc_en, 0);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("lat_T1_en", wrc_en, 2'b01);
      chk("lat_T1_addr", wrc_addr, 15'h0042);
      chk("lat_T1_word", wrc_word, 64'h1111_2222_3333_4444);
      chk("lat_T1_busy", busy, 1);
      chk("lat_T1_ready", cmd_ready, 0);
      @(negedge clk);
      chk("lat_T2_done", done, 1);
      chk("lat_T2_en", wrc_en, 0);
      @(negedge clk);
      chk("lat_T3_done", done, 0);
      chk("lat_T3_ready", cmd_ready, 1);

      // Zero mask: done without writes, err set, cleared by the next accept.
      got_q.delete();
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_mask = 2'b00; cmd_fill = 1'b1; cmd_len = 15'd4;
      @(negedge clk);
      chk("zm_ready", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("zm_done", done, 1);
      chk("zm_err", err, 1);
      chk("zm_en", wrc_en, 0);
      @(negedge clk);
      chk("zm_done_low", done, 0);
      chk("zm_err_sticky", err, 1);
      chk("zm_nwr", got_q.size(), 0);
      c = '{15'h0300, 15'd1, 2'b01, 1'b1, 64'h5555_aaaa_5555_aaaa, 100, 100, 1, 0, 2};
      start_cmd(c);
      @(negedge clk);
      chk("zm_err_cleared", err, 0);
      finish_cmd("zm_next", 1'b0, 2, 0, 200);

      // Stream with grant stall: outputs held, order preserved.
      c = '{15'h4000, 15'd1, 2'b01, 1'b0, 64'ha5a5_a5a5_a5a5_a5a5, 0, 100, 0, 0, 2};
      start_cmd(c);
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (wrc_en != 2'b00) break;
      end
      repeat (3) @(negedge clk);
      chk("stall_en", wrc_en, 2'b01);
      chk("stall_addr", wrc_addr, 15'h4000);
      chk("stall_word", wrc_word, 64'ha5a5_a5a5_a5a5_a5a5);
      gnt_pct = 100;
      finish_cmd("stall", 1'b0, 2, 2, 200);

      // Stream back-pressure: FIFO fills at 4 with no grant, then drains all 8.
      c = '{15'h0200, 15'd7, 2'b01, 1'b0, 64'h0, 0, 100, 1, 0, 8};
      start_cmd(c);
      repeat (12) @(negedge clk);
      chk("bp_push4", push_cnt, 4);
      chk("bp_s_ready", s_ready, 0);
      chk("bp_no_wr", got_q.size(), 0);
      gnt_pct = 100;
      finish_cmd("bp", 1'b0, 8, 8, 400);
      chk("bp_s_ready_end", s_ready, 0);

      // Reset mid-burst, then a fresh stream burst must see only its own words.
      c = '{15'h0500, 15'd5, 2'b01, 1'b0, 64'h0, 100, 100, 1, 0, 6};
      start_cmd(c);
      for (int n = 0; n < 50; n++) begin
         @(negedge clk); #1;
         if (got_q.size() >= 1) break;
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_en", wrc_en, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_ready", cmd_ready, 1);
      chk("mrst_s_ready", s_ready, 0);
      chk("mrst_err", err, 0);
      c = '{15'h0600, 15'd5, 2'b11, 1'b0, 64'h0, 70, 60, 1, 0, 6};
      start_cmd(c);
      finish_cmd("mrst_next", 1'b0, 6, 6, 400);

      // Random commands against the model.
      for (int r = 0; r < 40; r++) begin
         c.addr     = ($urandom_range(3) == 0) ? 15'(15'h7FF0 + 15'($urandom_range(15))) : 15'($urandom);
         c.len      = 15'($urandom_range(12));
         c.mask     = ($urandom_range(7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         c.fill     = 1'($urandom_range(1));
         c.word     = {$urandom, $urandom};
         c.gnt_pct  = pct_tab[$urandom_range(2)];
         c.prod_pct = int'($urandom_range(30, 100));
         c.rnd      = 1'b1;
         start_cmd(c);
         finish_cmd($sformatf("rnd%0d", r), exp_err_m, exp_q.size(),
                    (!c.fill && c.mask != 2'b00) ? int'(c.len) + 1 : 0,
                    40 * (int'(c.len) + 1) + 100);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
